rf80386_bus_arbiter: RTL and testbench
======================================

Name: rf80386_bus_arbiter

Overview:
- Shares the single external 32-bit bus among three internal requesters of the 80386 core:
  - m0: execute-side data load/store, I/O and stack accesses.
  - m1: descriptor fetch walker (GDT/LDT/IDT reads).
  - m2: instruction prefetch.
- Fixed priority m0 > m1 > m2, with anti-starvation for m2, bus-lock hold and per-master ack/data routing.
- Sits between the core state machine / prefetch unit and the external bus interface.

Parameters:
- AWID, 32, address width.
- STARVE_LIM, 4, consecutive lost arbitrations after which m2 is promoted to top priority.
- TIMEOUT, 255, cycles without ack before abort (optional feature only).

Ports:
Ports prefixed mN_ are replicated for N = 0, 1, 2.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mN_cyc_i  in  1  master N bus cycle request
- mN_stb_i  in  1  master N strobe
- mN_we_i  in  1  master N write enable
- mN_sel_i  in  4  master N byte lanes
- mN_adr_i  in  AWID  master N address
- mN_dat_i  in  32  master N write data
- mN_lock_i  in  1  master N holds bus between cycles
- mN_ack_o  out  1  ack routed to master N
- mN_err_o  out  1  timeout abort to master N
- mN_gnt_o  out  1  master N owns bus
- cyc_o  out  1  bus cycle
- stb_o  out  1  bus strobe
- we_o  out  1  bus write enable
- sel_o  out  4  bus byte lanes
- adr_o  out  AWID  bus address
- dat_o  out  32  bus write data
- lock_o  out  1  bus lock
- ack_i  in  1  bus acknowledge
- dat_i  in  32  bus read data; fanned to all masters unregistered, qualified by mN_ack_o

Behaviour:
- Reset (rst_i sampled high at posedge):
  - State goes to IDLE.
  - All gnt/ack/err outputs are 0.
  - cyc_o, stb_o, we_o, lock_o are 0; sel_o is 0; adr_o is all ones; dat_o is 0.
  - Starvation counter is 0.
  - Reset mid-transfer abandons the cycle with no ack or err.
- States: IDLE, OWN, LOCKED. A registered owner index ow[1:0] selects the master.
- IDLE:
  - Evaluates mN_cyc_i.
  - Winner is m2 if starve_cnt == STARVE_LIM and m2_cyc_i; otherwise the lowest-numbered requester.
  - On any request: ow <= winner, next state OWN.
  - Grant latency is one cycle: a request at edge k gives gnt and cyc_o at edge k+1.
- OWN:
  - Bus outputs are a combinational mux of master ow: cyc, stb, we, sel, adr, dat, lock.
  - mN_ack_o = ack_i & (ow == N) & stb_o. Non-owners always see ack 0.
  - On owner cyc_i = 0 and lock_i = 1: go to LOCKED.
  - On owner cyc_i = 0 and lock_i = 0: go to IDLE.
  - Otherwise remain in OWN. The owner may issue back-to-back strobes, holding cyc between pause/continue.
- LOCKED:
  - cyc_o = stb_o = 0, lock_o = 1, gnt held.
  - Owner cyc_i = 1: go to OWN.
  - Owner lock_i = 0: go to IDLE.
  - Higher-priority requests wait.
- IDLE between owners: at least one cycle with cyc_o = 0 between different owners; no direct handoff.
- Starvation counter:
  - In IDLE, when a grant goes to m0/m1 while m2_cyc_i = 1: starve_cnt increments, saturating at STARVE_LIM.
  - Cleared on a grant to m2, or when m2_cyc_i = 0 in IDLE.
- Simultaneous events:
  - All three request in IDLE: winner is m0 unless m2 is promoted.
  - ack_i with owner dropping cyc the same cycle: ack is delivered, then the release takes effect.
- Outputs outside OWN: adr_o is all ones and dat_o is 0 in IDLE and LOCKED.

Optional Feature:
- Macro: RF80386_BUS_TIMEOUT_EN.
- When defined:
  - A counter runs while in OWN with stb_o = 1 and ack_i = 0; it clears on ack_i or when stb_o = 0.
  - When the count reaches TIMEOUT, mN_err_o of the owner pulses for one cycle and the state is forced to IDLE, ignoring lock.
  - The owner must drop cyc on err.
- When undefined: no counter; all mN_err_o are tied 0; a slave that never acks stalls the bus forever.

Test Plan:
1. Reset: rst_i = 1 for 2 cycles with all cyc high -> gnt 0, cyc_o 0, adr_o 32'hFFFFFFFF. First post-reset edge grants m0.
2. Priority: m1 and m2 raise cyc together at edge k -> m1_gnt_o = 1 at k+1, adr_o = m1_adr_i. After m1 drops cyc: one idle cycle, then m2 granted.
3. Ack routing: m0 owns, m0 read adr 32'h000FFFF0, ack_i pulses with dat_i = 32'h12345678 -> m0_ack_o = 1; m1_ack_o and m2_ack_o stay 0.
4. Lock: m0 with lock = 1 drops cyc for 3 cycles while m1 requests -> lock_o = 1, m0_gnt_o holds, m1 not granted. m0 reasserts cyc -> OWN without re-arbitration.
5. Starvation: m2 continuously requests while m0 issues 4 back-to-back transactions and m1 also requests -> after the 4th m0 grant, m2 wins the next IDLE ahead of m1.
6. RF80386_BUS_TIMEOUT_EN, TIMEOUT = 8: m1 strobes with ack_i held 0 -> m1_err_o pulses on the 8th stalled cycle, then state is IDLE next cycle.

Source files
------------

// File: rtl/rf80386_bus_arbiter.sv
// Purpose : shares the external 32-bit bus among m0 (execute), m1 (descriptor walker), m2 (prefetch).
// Latency : a request sampled in IDLE is granted on the next edge; the owner's bus signals pass through combinationally.
// Backpr. : losers wait with cyc held high; a lock holder keeps the bus between cycles; m2 is promoted after STARVE_LIM losses.
//
// Ports (mN_* replicated for N = 0..2):
//   clk_i, rst_i                      clock, synchronous active-high reset
//   mN_cyc/stb/we/sel/adr/dat/lock_i  master request and bus fields
//   mN_ack_o, mN_err_o, mN_gnt_o      routed ack, timeout abort, ownership
//   cyc/stb/we/sel/adr/dat/lock_o     external bus outputs
//   ack_i, dat_i                      external bus ack and read data
// Optional: define RF80386_BUS_TIMEOUT_EN to abort a stalled strobe after TIMEOUT cycles.

module rf80386_bus_arbiter #(
    parameter int AWID       = 32,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [3:0]      m0_sel_i,
    input  logic [AWID-1:0] m0_adr_i,
    input  logic [31:0]     m0_dat_i,
    input  logic            m0_lock_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_gnt_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [3:0]      m1_sel_i,
    input  logic [AWID-1:0] m1_adr_i,
    input  logic [31:0]     m1_dat_i,
    input  logic            m1_lock_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_gnt_o,

    input  logic            m2_cyc_i,
    input  logic            m2_stb_i,
    input  logic            m2_we_i,
    input  logic [3:0]      m2_sel_i,
    input  logic [AWID-1:0] m2_adr_i,
    input  logic [31:0]     m2_dat_i,
    input  logic            m2_lock_i,
    output logic            m2_ack_o,
    output logic            m2_err_o,
    output logic            m2_gnt_o,

    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [3:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [31:0]     dat_o,
    output logic            lock_o,
    input  logic            ack_i,
    input  logic [31:0]     dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    state_t        state, state_nxt;
    logic [1:0]    ow, ow_nxt;
    logic [SW-1:0] starve_cnt, starve_nxt;

    // Owner's request fields, selected by the registered owner index.
    logic            own_cyc, own_stb, own_we, own_lock;
    logic [3:0]      own_sel;
    logic [AWID-1:0] own_adr;
    logic [31:0]     own_dat;

    logic       any_req;
    logic       promote;
    logic [1:0] winner;
    logic       tmo_hit;

    // Read data is wired to every master outside this block; the arbiter
    // only qualifies it through the routed ack.
    logic unused_dat;
    assign unused_dat = ^dat_i;

    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_lock = 1'b0;
        own_sel  = '0;
        own_adr  = '1;
        own_dat  = '0;
        case (ow)
            2'd0: begin
                own_cyc = m0_cyc_i; own_stb = m0_stb_i; own_we  = m0_we_i;  own_lock = m0_lock_i;
                own_sel = m0_sel_i; own_adr = m0_adr_i; own_dat = m0_dat_i;
            end
            2'd1: begin
                own_cyc = m1_cyc_i; own_stb = m1_stb_i; own_we  = m1_we_i;  own_lock = m1_lock_i;
                own_sel = m1_sel_i; own_adr = m1_adr_i; own_dat = m1_dat_i;
            end
            2'd2: begin
                own_cyc = m2_cyc_i; own_stb = m2_stb_i; own_we  = m2_we_i;  own_lock = m2_lock_i;
                own_sel = m2_sel_i; own_adr = m2_adr_i; own_dat = m2_dat_i;
            end
            default: ;
        endcase
    end

    // Bus outputs: pass-through of the owner in OWN, parked values elsewhere.
    always_comb begin
        cyc_o  = 1'b0;
        stb_o  = 1'b0;
        we_o   = 1'b0;
        sel_o  = '0;
        adr_o  = '1;
        dat_o  = '0;
        lock_o = (state == ST_LOCKED);
        if (state == ST_OWN) begin
            cyc_o  = own_cyc;
            stb_o  = own_stb;
            we_o   = own_we;
            sel_o  = own_sel;
            adr_o  = own_adr;
            dat_o  = own_dat;
            lock_o = own_lock;
        end
    end

    assign m0_gnt_o = (state != ST_IDLE) && (ow == 2'd0);
    assign m1_gnt_o = (state != ST_IDLE) && (ow == 2'd1);
    assign m2_gnt_o = (state != ST_IDLE) && (ow == 2'd2);

    // stb_o is only nonzero in OWN, so idle/locked acks never reach a master.
    assign m0_ack_o = ack_i && stb_o && (ow == 2'd0);
    assign m1_ack_o = ack_i && stb_o && (ow == 2'd1);
    assign m2_ack_o = ack_i && stb_o && (ow == 2'd2);

`ifdef RF80386_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;
    logic          stall;

    assign stall   = (state == ST_OWN) && stb_o && !ack_i;
    // Fires during the TIMEOUT-th consecutive stalled cycle.
    assign tmo_hit = stall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || !stall || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign m0_err_o = tmo_hit && (ow == 2'd0);
    assign m1_err_o = tmo_hit && (ow == 2'd1);
    assign m2_err_o = tmo_hit && (ow == 2'd2);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign tmo_hit  = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
    assign m2_err_o = 1'b0;
`endif

    assign any_req = m0_cyc_i || m1_cyc_i || m2_cyc_i;
    assign promote = (starve_cnt == STARVE_MAX) && m2_cyc_i;

    always_comb begin
        winner = 2'd2;
        if (promote)       winner = 2'd2;
        else if (m0_cyc_i) winner = 2'd0;
        else if (m1_cyc_i) winner = 2'd1;
    end

    always_comb begin
        state_nxt  = state;
        ow_nxt     = ow;
        starve_nxt = starve_cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    ow_nxt    = winner;
                    state_nxt = ST_OWN;
                end
                // m2 only counts as starved while it is actually waiting.
                if (!m2_cyc_i || (any_req && winner == 2'd2)) begin
                    starve_nxt = '0;
                end else if (any_req && starve_cnt != STARVE_MAX) begin
                    starve_nxt = starve_cnt + 1'b1;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_nxt = own_lock ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (own_cyc)       state_nxt = ST_OWN;
                else if (!own_lock) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A timed-out owner loses the bus even if it asked for a lock.
        if (tmo_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            ow         <= 2'd0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            ow         <= ow_nxt;
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// Purpose : scoreboard bench for rf80386_bus_arbiter (grant order, ack routing, lock, starvation).
// Latency : stimulus drives 1ns after posedge; monitor samples on negedge.
// Backpr. : every expected grant/ack/err is queued by the stimulus and popped by the monitor.

module tb_rf80386_bus_arbiter;

    localparam int EV_GNT = 0;
    localparam int EV_ACK = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int          kind;
        int          m;
        logic [31:0] adr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cyc, stb, we, lock;
    logic [3:0]  sel  [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic        ack_i;
    logic [31:0] dat_i;

    logic [2:0]  gnt, ack, err;
    logic        cyc_o, stb_o, we_o, lock_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [2:0]  prev_g   = 3'b000;

    always #5 clk = ~clk;

    rf80386_bus_arbiter #(.AWID(32), .STARVE_LIM(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_lock_i(lock[0]),
        .m0_ack_o(ack[0]), .m0_err_o(err[0]), .m0_gnt_o(gnt[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_lock_i(lock[1]),
        .m1_ack_o(ack[1]), .m1_err_o(err[1]), .m1_gnt_o(gnt[1]),
        .m2_cyc_i(cyc[2]), .m2_stb_i(stb[2]), .m2_we_i(we[2]), .m2_sel_i(sel[2]),
        .m2_adr_i(adr[2]), .m2_dat_i(wdat[2]), .m2_lock_i(lock[2]),
        .m2_ack_o(ack[2]), .m2_err_o(err[2]), .m2_gnt_o(gnt[2]),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .lock_o(lock_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int m, input logic [31:0] a);
        exp_t e;
        e.kind = kind;
        e.m    = m;
        e.adr  = a;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops the next expected event and compares it against what the DUT shows.
    task automatic pop_cmp(input int kind, input logic [2:0] vec);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d vec %b with empty scoreboard", kind, vec);
            return;
        end
        e = q.pop_front();
        if (e.kind != kind || vec !== (3'b001 << e.m) || adr_o !== e.adr) begin
            failures++;
            $display("FAIL event_%0d: got kind %0d vec %b adr %h, expected kind %0d master %0d adr %h",
                     checks, kind, vec, adr_o, e.kind, e.m, e.adr);
        end
    endtask

    // Monitor: grant rising edges, routed acks and err pulses.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((gnt & ~prev_g) != 3'b000) begin
                checks++;
                if (prev_g != 3'b000) begin
                    failures++;
                    $display("FAIL idle_gap: grant %b followed %b with no idle cycle", gnt, prev_g);
                end
                pop_cmp(EV_GNT, gnt & ~prev_g);
            end
            if (ack != 3'b000) pop_cmp(EV_ACK, ack);
            if (err != 3'b000) pop_cmp(EV_ERR, err);
        end
        prev_g = (rst === 1'b0) ? gnt : 3'b000;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        cyc   = 3'b111;
        stb   = 3'b000;
        we    = 3'b000;
        lock  = 3'b000;
        ack_i = 1'b0;
        dat_i = '0;
        for (int i = 0; i < 3; i++) begin
            sel[i]  = 4'hF;
            wdat[i] = 32'hA000_0000 + i;
        end
        adr[0] = 32'h0000_1000;
        adr[1] = 32'h0000_2000;
        adr[2] = 32'h0000_3000;

        // 1. Reset with all masters requesting.
        tick(2);
        check("rst_gnt",  {29'd0, gnt}, 32'd0);
        check("rst_cyc",  {31'd0, cyc_o}, 32'd0);
        check("rst_adr",  adr_o, 32'hFFFF_FFFF);
        check("rst_dat",  dat_o, 32'd0);
        check("rst_lock", {31'd0, lock_o}, 32'd0);
        expect_ev(EV_GNT, 0, 32'h0000_1000);
        rst = 1'b0;
        tick(1);
        check("first_gnt_m0", {29'd0, gnt}, 32'd1);
        cyc = 3'b000;
        tick(3);

        // 2. m1 and m2 together: m1 first, then m2 after an idle cycle.
        expect_ev(EV_GNT, 1, 32'h0000_2000);
        expect_ev(EV_GNT, 2, 32'h0000_3000);
        cyc = 3'b110;
        tick(1);
        check("prio_adr_m1", adr_o, 32'h0000_2000);
        tick(1);
        cyc[1] = 1'b0;
        tick(1);
        check("handoff_idle_cyc", {31'd0, cyc_o}, 32'd0);
        tick(1);
        check("handoff_gnt_m2", {29'd0, gnt}, 32'd4);
        cyc[2] = 1'b0;
        tick(2);

        // 3. Ack routing for an m0 read, then ack together with cyc drop.
        adr[0] = 32'h000F_FFF0;
        expect_ev(EV_GNT, 0, 32'h000F_FFF0);
        cyc[0] = 1'b1;
        tick(1);
        expect_ev(EV_ACK, 0, 32'h000F_FFF0);
        stb[0] = 1'b1;
        ack_i  = 1'b1;
        dat_i  = 32'h1234_5678;
        tick(1);
        ack_i = 1'b0;
        stb[0] = 1'b0;
        tick(1);
        expect_ev(EV_ACK, 0, 32'h000F_FFF0);
        stb[0] = 1'b1;
        cyc[0] = 1'b0;
        ack_i  = 1'b1;
        tick(1);
        stb[0] = 1'b0;
        ack_i  = 1'b0;
        check("release_after_ack", {29'd0, gnt}, 32'd0);
        ack_i = 1'b1;          // stray ack with no owner must not be routed
        tick(1);
        ack_i = 1'b0;
        tick(1);

        // 4. Lock hold by m0 while m1 waits.
        adr[0] = 32'h0000_4000;
        expect_ev(EV_GNT, 0, 32'h0000_4000);
        cyc[0]  = 1'b1;
        lock[0] = 1'b1;
        tick(1);
        cyc[0] = 1'b0;
        cyc[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("lock_lock_o", {31'd0, lock_o}, 32'd1);
            check("lock_gnt",    {29'd0, gnt}, 32'd1);
            check("lock_cyc_o",  {31'd0, cyc_o}, 32'd0);
            check("lock_adr_o",  adr_o, 32'hFFFF_FFFF);
        end
        cyc[0] = 1'b1;
        tick(1);
        check("relock_cyc_o", {31'd0, cyc_o}, 32'd1);
        check("relock_adr_o", adr_o, 32'h0000_4000);
        expect_ev(EV_GNT, 1, 32'h0000_2000);
        cyc[0]  = 1'b0;
        lock[0] = 1'b0;
        tick(2);
        cyc[1] = 1'b0;
        tick(2);

        // 5. Starvation: m0 wins four times, then m2 jumps ahead of m0 and m1.
        adr[0] = 32'h0000_5000;
        for (int i = 0; i < 4; i++) expect_ev(EV_GNT, 0, 32'h0000_5000);
        expect_ev(EV_GNT, 2, 32'h0000_3000);
        expect_ev(EV_GNT, 0, 32'h0000_5000);
        cyc = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            cyc[0] = 1'b0;
            tick(1);
            cyc[0] = 1'b1;
        end
        tick(1);
        check("starve_gnt_m2", {29'd0, gnt}, 32'd4);
        cyc[2] = 1'b0;
        tick(2);
        check("after_starve_m0", {29'd0, gnt}, 32'd1);
        cyc = 3'b000;
        tick(2);

`ifdef RF80386_BUS_TIMEOUT_EN
        // 6. Stalled m1 strobe aborted on the 8th stalled cycle.
        expect_ev(EV_GNT, 1, 32'h0000_2000);
        expect_ev(EV_ERR, 1, 32'h0000_2000);
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        tick(8);
        check("tmo_err_m1", {29'd0, err}, 32'd2);
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        tick(1);
        check("tmo_idle", {29'd0, gnt}, 32'd0);
`else
        check("err_tied_low", {29'd0, err}, 32'd0);
`endif

        tick(3);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
